seg7_scan_decoder: RTL and testbench

Reads the multiplexed, active-low 4-digit seven-segment bus (anodes plus {A..G} cathodes) driven by the display scanner and reconstructs the displayed 16-bit hex value. Sits beside the Basys3 display path as an on-chip monitor for self-checking tops and benches. It filters scan transitions, decodes each digit pattern back to a nibble and commits a coherent frame once all four digits have been seen.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_pattern_decode.sv | 29 ++
 rtl/seg7_scan_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: pattern type, hex encoder table and
// the scan-decoder state encoding.
package seg7_pkg;

   typedef logic [6:0] seg_pattern_t;

   localparam seg_pattern_t SEG_BLANK = 7'h7F;

   // Active-low {A..G} patterns for hex digits 0..F, same table as the encoder.
   localparam seg_pattern_t HEX_PATTERNS [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

   typedef enum logic [1:0] {
      EMPTY  = 2'd0,
      FILL   = 2'd1,
      COMMIT = 2'd2
   } state_e;

   typedef struct packed {
      logic [3:0]   an;
      seg_pattern_t seg;
   } scan_sample_t;

   // True when exactly one active-low anode is driven.
   function automatic logic single_low(input logic [3:0] an);
      logic [3:0] act;
      act = ~an;
      return (act != 4'h0) && ((act & (act - 4'd1)) == 4'h0);
   endfunction

   function automatic logic [1:0] low_index(input logic [3:0] an);
      logic [1:0] idx;
      if (!an[0])      idx = 2'd0;
      else if (!an[1]) idx = 2'd1;
      else if (!an[2]) idx = 2'd2;
      else             idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex encoder table: segment pattern to
// {known, blank, nibble}. Unknown patterns report nibble 0.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] pattern_i,
   output logic       known_o,
   output logic       blank_o,
   output logic [3:0] nibble_o
);

   logic [15:0] hit;

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_match
         assign hit[gi] = (pattern_i == HEX_PATTERNS[gi]);
      end
   endgenerate

   always_comb begin
      nibble_o = 4'h0;
      for (int i = 0; i < 16; i++) begin
         if (hit[i]) nibble_o = 4'(i);
      end
      blank_o = (pattern_i == SEG_BLANK);
      known_o = blank_o || (hit != 16'h0000);
   end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Reconstructs the 16-bit hex value shown on a multiplexed 4-digit 7-seg bus.
// Optional feature macro: SEG7_SCAN_ERR_EN (unknown patterns flagged, not captured).
module seg7_scan_decoder
   import seg7_pkg::*;
#(
   parameter int STABLE_CYCLES  = 4,
   parameter int TIMEOUT_CYCLES = 1048576
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [3:0]  an_i,
   input  logic [6:0]  seg_i,
   output logic [15:0] value_o,
   output logic        valid_o,
   output logic        update_o,
   output logic [3:0]  blank_o,
   output logic [3:0]  error_o
);

   localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_CYCLES);
   localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT_CYCLES);

   scan_sample_t      smp_reg, prev_reg;
   logic [STAB_W-1:0] stab_cnt_reg, stab_cnt_next;
   logic              done_reg, done_next;
   logic [TO_W-1:0]   to_cnt_reg, to_cnt_next;
   state_e            state_reg, state_next;
   logic [3:0]        mask_reg, mask_next;
   logic [3:0]        shadow_nib_reg [4];
   logic              shadow_blank_reg [4];
   logic [15:0]       shadow_val;
   logic [3:0]        shadow_blank;
   logic [15:0]       value_reg;
   logic [3:0]        blank_reg;
   logic              valid_reg, valid_next;
   logic              update_reg;

   logic              sel, changed, capture, cap_ok;
   logic [1:0]        cap_idx;
   logic [3:0]        digit_sel;
   logic              dec_known, dec_blank;
   logic [3:0]        dec_nibble, cap_nibble;
   logic              commit_en, flush_en;

   // Input stage: every decision below is made on the registered sample.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         smp_reg  <= '{an: 4'hF, seg: SEG_BLANK};
         prev_reg <= '{an: 4'hF, seg: SEG_BLANK};
      end else begin
         smp_reg  <= '{an: an_i, seg: seg_i};
         prev_reg <= smp_reg;
      end
   end

   assign sel     = single_low(smp_reg.an);
   assign cap_idx = low_index(smp_reg.an);
   assign changed = (smp_reg != prev_reg);

   always_comb begin
      stab_cnt_next = stab_cnt_reg;
      if (!sel)                      stab_cnt_next = '0;
      else if (changed)              stab_cnt_next = STAB_W'(1);
      else if (stab_cnt_reg < STAB_MAX) stab_cnt_next = stab_cnt_reg + STAB_W'(1);
   end

   // One capture per dwell: done blocks re-firing until the sample moves.
   assign capture = sel && !done_reg && (stab_cnt_next == STAB_MAX);

   always_comb begin
      done_next = done_reg;
      if (!sel || changed) done_next = 1'b0;
      else if (capture)    done_next = 1'b1;
   end

   always_comb begin
      to_cnt_next = to_cnt_reg;
      if (capture)                  to_cnt_next = '0;
      else if (to_cnt_reg < TO_MAX) to_cnt_next = to_cnt_reg + TO_W'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stab_cnt_reg <= '0;
         done_reg     <= 1'b0;
         to_cnt_reg   <= '0;
      end else begin
         stab_cnt_reg <= stab_cnt_next;
         done_reg     <= done_next;
         to_cnt_reg   <= to_cnt_next;
      end
   end

   seg7_pattern_decode u_decode (
      .pattern_i (smp_reg.seg),
      .known_o   (dec_known),
      .blank_o   (dec_blank),
      .nibble_o  (dec_nibble)
   );

   assign cap_nibble = dec_known ? dec_nibble : 4'h0;

`ifdef SEG7_SCAN_ERR_EN
   logic       cap_err;
   logic [3:0] error_reg, error_next;
   assign cap_ok  = capture && dec_known;
   assign cap_err = capture && !dec_known;
`else
   assign cap_ok  = capture;
`endif

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_digit
         assign digit_sel[gi] = (cap_idx == 2'(gi));
         assign mask_next[gi] = (cap_ok && digit_sel[gi]) ||
                                (mask_reg[gi] && !commit_en && !flush_en);
         assign shadow_val[4*gi +: 4] = shadow_nib_reg[gi];
         assign shadow_blank[gi]      = shadow_blank_reg[gi];

         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               shadow_nib_reg[gi]   <= 4'h0;
               shadow_blank_reg[gi] <= 1'b0;
            end else if (cap_ok && digit_sel[gi]) begin
               shadow_nib_reg[gi]   <= cap_nibble;
               shadow_blank_reg[gi] <= dec_blank;
            end
         end
`ifdef SEG7_SCAN_ERR_EN
         assign error_next[gi] = (cap_err && digit_sel[gi]) ||
                                 (error_reg[gi] && !commit_en);
`endif
      end
   endgenerate

`ifdef SEG7_SCAN_ERR_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) error_reg <= 4'h0;
      else         error_reg <= error_next;
   end
   assign error_o = error_reg;
`else
   assign error_o = 4'h0;
`endif

   // FSM: state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_reg <= EMPTY;
      else         state_reg <= state_next;
   end

   // FSM: next state
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         EMPTY:   if (capture) state_next = FILL;
         FILL: begin
            if (flush_en)              state_next = EMPTY;
            else if (mask_reg == 4'hF) state_next = COMMIT;
         end
         COMMIT:  state_next = FILL;
         default: state_next = EMPTY;
      endcase
   end

   // FSM: outputs. A capture always restarts the timeout, so a flush
   // can never land on the same cycle as a capture or a commit.
   always_comb begin
      commit_en = (state_reg == COMMIT);
      flush_en  = (state_reg != COMMIT) && (to_cnt_reg == TO_MAX) && !capture;
      valid_next = valid_reg;
      if (commit_en)     valid_next = 1'b1;
      else if (flush_en) valid_next = 1'b0;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         mask_reg   <= 4'h0;
         value_reg  <= 16'h0000;
         blank_reg  <= 4'h0;
         valid_reg  <= 1'b0;
         update_reg <= 1'b0;
      end else begin
         mask_reg   <= mask_next;
         valid_reg  <= valid_next;
         update_reg <= commit_en;
         if (commit_en) begin
            value_reg <= shadow_val;
            blank_reg <= shadow_blank;
         end
      end
   end

   assign value_o  = value_reg;
   assign blank_o  = blank_reg;
   assign valid_o  = valid_reg;
   assign update_o = update_reg;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Scoreboard bench for seg7_scan_decoder: stimulus queues expected frames,
// a monitor pops and compares one entry per update_o pulse.
module tb_seg7_scan_decoder;

   localparam int STABLE  = 4;
   localparam int TIMEOUT = 200;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [3:0]  an_i = 4'hF;
   logic [6:0]  seg_i = 7'h7F;
   logic [15:0] value_o;
   logic        valid_o;
   logic        update_o;
   logic [3:0]  blank_o;
   logic [3:0]  error_o;

   typedef struct {
      logic [15:0] v;
      logic [3:0]  b;
      logic [3:0]  e;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;
   int   n_upd = 0;
   int   saved_upd;

   seg7_scan_decoder #(
      .STABLE_CYCLES  (STABLE),
      .TIMEOUT_CYCLES (TIMEOUT)
   ) dut (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .an_i     (an_i),
      .seg_i    (seg_i),
      .value_o  (value_o),
      .valid_o  (valid_o),
      .update_o (update_o),
      .blank_o  (blank_o),
      .error_o  (error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, expv);
      end
   endtask

   task automatic expect_frame(input logic [15:0] v, input logic [3:0] b, input logic [3:0] e);
      exp_t x;
      x.v = v; x.b = b; x.e = e;
      exp_q.push_back(x);
   endtask

   // Drive one bus state for n clock edges; returns 1 time unit after an edge.
   task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
      an_i  = an;
      seg_i = seg;
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic scan(input logic [6:0] p0, input logic [6:0] p1,
                       input logic [6:0] p2, input logic [6:0] p3, input int n);
      hold(4'b1110, p0, n);
      hold(4'b1101, p1, n);
      hold(4'b1011, p2, n);
      hold(4'b0111, p3, n);
      hold(4'b1111, 7'h7F, 2);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk_i);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
   endtask

   // Monitor: one scoreboard pop per commit pulse.
   always @(negedge clk_i) begin
      if (rst_ni && update_o) begin
         exp_t x;
         n_upd++;
         $display("txn commit value=%h blank=%b err=%b valid=%b", value_o, blank_o, error_o, valid_o);
         if (exp_q.size() == 0) begin
            check("unexpected_update", 32'(value_o), 32'hFFFF_FFFF);
         end else begin
            x = exp_q.pop_front();
            check("commit_value", 32'(value_o), 32'(x.v));
            check("commit_blank", 32'(blank_o), 32'(x.b));
            check("commit_error", 32'(error_o), 32'(x.e));
            check("commit_valid", 32'(valid_o), 32'd1);
         end
      end
   end

   initial begin
      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      check("rst_value", 32'(value_o), 32'h0);
      check("rst_valid", 32'(valid_o), 32'h0);
      check("rst_update", 32'(update_o), 32'h0);
      check("rst_blank", 32'(blank_o), 32'h0);
      check("rst_error", 32'(error_o), 32'h0);
      rst_ni = 1'b1;
      hold(4'hF, 7'h7F, 2);

      // Basic frame 1,2,3,4
      expect_frame(16'h4321, 4'h0, 4'h0);
      scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
      drain("frame_4321_drain");
      check("frame_4321_valid", 32'(valid_o), 32'd1);

      // Short dwell (3 samples) is ignored entirely
      do_reset();
      saved_upd = n_upd;
      for (int r = 0; r < 3; r++) scan(7'h79, 7'h24, 7'h30, 7'h19, 3);
      hold(4'hF, 7'h7F, 10);
      check("short_dwell_valid", 32'(valid_o), 32'd0);
      check("short_dwell_updates", 32'(n_upd), 32'(saved_upd));

      // Two anodes active never captures; three digits alone never commit
      hold(4'b0011, 7'h40, 20);
      hold(4'b1110, 7'h40, 8);
      hold(4'b1101, 7'h79, 8);
      hold(4'b1011, 7'h24, 8);
      hold(4'hF, 7'h7F, 10);
      check("multi_anode_updates", 32'(n_upd), 32'(saved_upd));
      expect_frame(16'h3210, 4'h0, 4'h0);
      hold(4'b0111, 7'h30, 8);
      hold(4'hF, 7'h7F, 4);
      drain("frame_3210_drain");

      // Blank digit 2
      expect_frame(16'hA0AA, 4'b0100, 4'h0);
      scan(7'h08, 7'h08, 7'h7F, 7'h08, 8);
      drain("frame_blank_drain");

      // Unknown pattern on digit 1
      saved_upd = n_upd;
`ifdef SEG7_SCAN_ERR_EN
      scan(7'h40, 7'h55, 7'h24, 7'h30, 8);
      hold(4'hF, 7'h7F, 6);
      check("unknown_error_flag", 32'(error_o), 32'h2);
      check("unknown_no_commit", 32'(n_upd), 32'(saved_upd));
      expect_frame(16'h3210, 4'h0, 4'h0);
      hold(4'b1101, 7'h79, 8);
      hold(4'hF, 7'h7F, 4);
      drain("unknown_fix_drain");
      check("unknown_error_cleared", 32'(error_o), 32'h0);
`else
      expect_frame(16'h3200, 4'h0, 4'h0);
      scan(7'h40, 7'h55, 7'h24, 7'h30, 8);
      drain("unknown_commit_drain");
      check("unknown_error_tied", 32'(error_o), 32'h0);
`endif

      // Timeout drops valid but keeps value
      expect_frame(16'h4321, 4'h0, 4'h0);
      scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
      drain("timeout_frame_drain");
      saved_upd = n_upd;
      hold(4'hF, 7'h7F, TIMEOUT / 2);
      check("before_timeout_valid", 32'(valid_o), 32'd1);
      hold(4'hF, 7'h7F, TIMEOUT / 2 + 20);
      check("after_timeout_valid", 32'(valid_o), 32'd0);
      check("after_timeout_value", 32'(value_o), 32'h4321);
      check("after_timeout_updates", 32'(n_upd), 32'(saved_upd));

      // Recommit, then asynchronous reset mid-scan
      expect_frame(16'h4321, 4'h0, 4'h0);
      scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
      drain("pre_reset_drain");
      hold(4'b1110, 7'h79, 8);
      hold(4'b1101, 7'h24, 2);
      #2 rst_ni = 1'b0;
      #1;
      check("async_rst_value", 32'(value_o), 32'h0);
      check("async_rst_valid", 32'(valid_o), 32'h0);
      check("async_rst_blank", 32'(blank_o), 32'h0);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      saved_upd = n_upd;
      hold(4'b1011, 7'h30, 8);
      hold(4'b0111, 7'h19, 8);
      hold(4'hF, 7'h7F, 10);
      check("post_rst_partial_updates", 32'(n_upd), 32'(saved_upd));
      check("post_rst_partial_valid", 32'(valid_o), 32'd0);
      expect_frame(16'h4321, 4'h0, 4'h0);
      scan(7'h79, 7'h24, 7'h30, 7'h19, 8);
      drain("post_rst_frame_drain");
      check("post_rst_valid", 32'(valid_o), 32'd1);

      hold(4'hF, 7'h7F, 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
